// File: rtl/fifo_ctrl_pkg.sv
// Shared widths and the round-robin search used by the FIFO push/pop controller.
package fifo_ctrl_pkg;

  localparam int MAX_REQ_W = 5;
  localparam int MAX_REQ   = 1 << MAX_REQ_W;

  // One spare bit so occupancy arithmetic can subtract a dequeue without wrapping.
  function automatic int CNT_W(input int num_loops);
    return $clog2(num_loops + 1) + 1;
  endfunction

  // First requester at or after ptr (circularly); returns ptr when nobody requests.
  function automatic int rr_next(input int ptr, input logic [MAX_REQ-1:0] req, input int num_req);
    int   sel;
    int   idx;
    logic found;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if ((k < num_req) && !found) begin
        idx = (ptr + k) % num_req;
        if (req[MAX_REQ_W'(idx)]) begin
          sel   = idx;
          found = 1'b1;
        end
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/fifo_ctrl_skid_buf.sv
// Small ring buffer absorbing FIFO pop data while the output stream is stalled.
module fifo_ctrl_skid_buf
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int WIDTH = 11
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    wr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd,
  output logic [WIDTH-1:0]        rd_data,
  output logic [CNT_W(DEPTH)-1:0] cnt,
  output logic                    not_empty
);

  localparam int CW = CNT_W(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    cnt_r;
  logic             wr_en_s;
  logic             rd_en_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + 1'b1;
  endfunction

  // Read/write qualification and gated head output
  always_comb begin
    rd_en_s   = rd & (cnt_r != {CW{1'b0}});
    wr_en_s   = wr & ((cnt_r != CW'(DEPTH)) | rd_en_s);
    not_empty = (cnt_r != {CW{1'b0}});
    cnt       = cnt_r;
    if (not_empty) begin
      rd_data = mem_r[rd_ptr_r];
    end else begin
      rd_data = {WIDTH{1'b0}};
    end
  end

  // Storage array
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      if (wr_en_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (rd_en_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({wr_en_s, rd_en_s})
        2'b10:   cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/fifo_push_arb_ctrl_chk.sv
// Protocol and configuration assertions for the FIFO push/pop controller.
module fifo_push_arb_ctrl_chk #(
  parameter int NUM_REQ = 4,
  parameter bit CFG_OK  = 1'b1
) (
  input logic               clk,
  input logic               rstn,
  input logic               push,
  input logic               full,
  input logic               pop,
  input logic               empty,
  input logic [NUM_REQ-1:0] req_ready,
  input logic               buf_ovf
);

  a_cfg:        assert property (@(posedge clk) CFG_OK);
  a_push_full:  assert property (@(posedge clk) disable iff (!rstn) !(push && full));
  a_pop_empty:  assert property (@(posedge clk) disable iff (!rstn) !(pop && empty));
  a_grant_1hot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(req_ready));
  a_buf_ovf:    assert property (@(posedge clk) disable iff (!rstn) !buf_ovf);

endmodule

// File: rtl/fifo_push_arb_ctrl.sv
// Round-robin push arbiter and latency-aware pop sequencer around a shared FIFO.
module fifo_push_arb_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_WIDTH = 11,
  parameter int NUM_LOOPS  = 3,
  parameter int ADD_MODE   = 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          push,
  output logic [FIFO_WIDTH-1:0]         push_data,
  input  logic                          full,
  output logic                          pop,
  input  logic                          empty,
  input  logic [FIFO_WIDTH-1:0]         pop_data,
  output logic                          out_valid,
  output logic [FIFO_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
  output logic                          busy
);

  localparam int CW = CNT_W(NUM_LOOPS);
  localparam int IW = $clog2(NUM_REQ);
  localparam bit CFG_OK = (NUM_REQ >= 2) && (NUM_REQ <= MAX_REQ) && (NUM_LOOPS >= 1) &&
                          (FIFO_DEPTH >= 1) && (FIFO_WIDTH >= 1) && (ADD_MODE >= 0);

  logic [IW-1:0]         rr_ptr_r;
  logic [IW-1:0]         grant_idx_s;
  logic                  grant_ok_s;
  logic [NUM_LOOPS-1:0]  pop_sr_r;
  logic [NUM_LOOPS:0]    pop_sr_nxt_s;
  logic [CW-1:0]         inflight_s;
  logic [CW-1:0]         buf_cnt_s;
  logic [CW-1:0]         occ_s;
  logic                  deq_s;
  logic                  pop_s;
  logic                  buf_wr_s;
  logic                  buf_ovf_s;
  logic                  not_empty_s;
  logic [FIFO_WIDTH-1:0] buf_data_s;

  // Grant selection and push-port mux
  always_comb begin
    grant_idx_s = IW'(rr_next(int'(rr_ptr_r), MAX_REQ'(req_valid), NUM_REQ));
    grant_ok_s  = en & ~full & (|req_valid);
    if (grant_ok_s) begin
      req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
      push_data = req_data[grant_idx_s*FIFO_WIDTH +: FIFO_WIDTH];
    end else begin
      req_ready = {NUM_REQ{1'b0}};
      push_data = {FIFO_WIDTH{1'b0}};
    end
    push = grant_ok_s;
  end

  // Round-robin pointer moves past the winner only when a push happens
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_r <= {IW{1'b0}};
    end else if (grant_ok_s) begin
      if (grant_idx_s == IW'(NUM_REQ - 1)) rr_ptr_r <= {IW{1'b0}};
      else                                 rr_ptr_r <= grant_idx_s + 1'b1;
    end
  end

  // Pop only if every outstanding word still has a skid slot after this cycle's dequeue
  always_comb begin
    inflight_s   = CW'($countones(pop_sr_r));
    deq_s        = not_empty_s & out_ready;
    occ_s        = inflight_s + buf_cnt_s - {{(CW-1){1'b0}}, deq_s};
    pop_s        = en & ~empty & (occ_s < CW'(NUM_LOOPS));
    pop_sr_nxt_s = {pop_sr_r, pop_s};
    buf_wr_s     = pop_sr_r[NUM_LOOPS-1];
    buf_ovf_s    = buf_wr_s & (buf_cnt_s == CW'(NUM_LOOPS)) & ~deq_s;
    pop          = pop_s;
    out_valid    = not_empty_s;
    out_data     = buf_data_s;
    busy         = (|pop_sr_r) | (buf_cnt_s != {CW{1'b0}});
  end

  // Pop latency tracker
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pop_sr_r <= {NUM_LOOPS{1'b0}};
    else       pop_sr_r <= pop_sr_nxt_s[NUM_LOOPS-1:0];
  end

  fifo_ctrl_skid_buf #(
    .DEPTH (NUM_LOOPS),
    .WIDTH (FIFO_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .wr        (buf_wr_s),
    .wr_data   (pop_data),
    .rd        (deq_s),
    .rd_data   (buf_data_s),
    .cnt       (buf_cnt_s),
    .not_empty (not_empty_s)
  );

  fifo_push_arb_ctrl_chk #(
    .NUM_REQ (NUM_REQ),
    .CFG_OK  (CFG_OK)
  ) u_chk (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .full      (full),
    .pop       (pop),
    .empty     (empty),
    .req_ready (req_ready),
    .buf_ovf   (buf_ovf_s)
  );

endmodule
